thiele_dual_solver_sequencer: RTL and testbench

Run controller that launches the sequential graph solver and the autonomous graph solver together, waits for both, and bounds the wait with a cycle timeout. It latches each solver's colouring and μ-accounting on its first done, compares the two result sets field by field, and reports one verdict per run over a valid/ready handshake. It sits between the host/CSR run-request logic and the two solver instances, and is the hardware equivalent of the dual-solver cross-check.

---
 rtl/thiele_dual_solver_sequencer.sv | 172 +++++++++++++++++
 tb/tb_thiele_dual_solver_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/thiele_dual_solver_sequencer.sv
// Launches the sequential and autonomous graph solvers together, captures each side's first result,
// and reports one field-by-field verdict per run (or a timeout) over a valid/ready handshake.
module thiele_dual_solver_sequencer #(
    parameter int NODES          = 9,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_req,
    output logic                 run_ack,
    output logic                 solver_start,
    input  logic                 seq_done,
    input  logic [2*NODES-1:0]   seq_colouring,
    input  logic [31:0]          seq_mu_question,
    input  logic [31:0]          seq_mu_info,
    input  logic [31:0]          seq_mu_total,
    input  logic [5:0]           seq_mu_legacy,
    input  logic                 auto_done,
    input  logic [2*NODES-1:0]   auto_colouring,
    input  logic [31:0]          auto_mu_question,
    input  logic [31:0]          auto_mu_info,
    input  logic [31:0]          auto_mu_total,
    input  logic [5:0]           auto_mu_legacy,
    input  logic [7:0]           auto_backtracks,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 match,
    output logic [4:0]           mismatch_mask,
    output logic                 timed_out,
    output logic [CNT_W-1:0]     seq_cycles,
    output logic [CNT_W-1:0]     auto_cycles,
    output logic [7:0]           backtracks,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    // Handshake: a verdict transfers on a cycle where result_valid && result_ready are both high;
    // result_valid and every result output stay constant from assertion until that transfer.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_COMPARE = 3'd3,
        S_REPORT  = 3'd4
    } state_t;

    localparam int CW = 2 * NODES;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             seq_got, auto_got;
    logic [CW-1:0]    seq_col_q, auto_col_q;
    logic [31:0]      seq_q_q, auto_q_q, seq_i_q, auto_i_q, seq_t_q, auto_t_q;
    logic [5:0]       seq_l_q, auto_l_q;

    logic [CNT_W-1:0] wait_inc;
    logic             seq_take, auto_take, both_fin;
    logic [4:0]       mask_c;

    always_comb begin
        wait_inc  = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
        seq_take  = seq_done && !seq_got;
        auto_take = auto_done && !auto_got;
        both_fin  = (seq_got || seq_done) && (auto_got || auto_done);
        // Case inequality so an X/Z on either side shows up as a mismatch, never as a silent pass.
        mask_c    = {seq_l_q !== auto_l_q, seq_t_q !== auto_t_q, seq_i_q !== auto_i_q,
                     seq_q_q !== auto_q_q, seq_col_q !== auto_col_q};
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            run_ack       <= 1'b0;
            solver_start  <= 1'b0;
            result_valid  <= 1'b0;
            match         <= 1'b0;
            mismatch_mask <= '0;
            timed_out     <= 1'b0;
            seq_cycles    <= '0;
            auto_cycles   <= '0;
            backtracks    <= '0;
            wait_cnt      <= '0;
            seq_got       <= 1'b0;
            auto_got      <= 1'b0;
            seq_col_q     <= '0;  auto_col_q <= '0;
            seq_q_q       <= '0;  auto_q_q   <= '0;
            seq_i_q       <= '0;  auto_i_q   <= '0;
            seq_t_q       <= '0;  auto_t_q   <= '0;
            seq_l_q       <= '0;  auto_l_q   <= '0;
        end else begin
            run_ack      <= 1'b0;
            solver_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run_req) begin
                        // Ack and start pulse are both visible during the LAUNCH cycle.
                        run_ack       <= 1'b1;
                        solver_start  <= 1'b1;
                        match         <= 1'b0;
                        mismatch_mask <= '0;
                        timed_out     <= 1'b0;
                        seq_cycles    <= '0;
                        auto_cycles   <= '0;
                        backtracks    <= '0;
                        wait_cnt      <= '0;
                        seq_got       <= 1'b0;
                        auto_got      <= 1'b0;
                        seq_col_q     <= '0;  auto_col_q <= '0;
                        seq_q_q       <= '0;  auto_q_q   <= '0;
                        seq_i_q       <= '0;  auto_i_q   <= '0;
                        seq_t_q       <= '0;  auto_t_q   <= '0;
                        seq_l_q       <= '0;  auto_l_q   <= '0;
                        state         <= S_LAUNCH;
                    end
                end
                S_LAUNCH: state <= S_WAIT;
                S_WAIT: begin
                    wait_cnt <= wait_inc;
                    if (seq_take) begin
                        seq_got    <= 1'b1;
                        seq_cycles <= wait_inc;
                        seq_col_q  <= seq_colouring;
                        seq_q_q    <= seq_mu_question;
                        seq_i_q    <= seq_mu_info;
                        seq_t_q    <= seq_mu_total;
                        seq_l_q    <= seq_mu_legacy;
                    end
                    if (auto_take) begin
                        auto_got    <= 1'b1;
                        auto_cycles <= wait_inc;
                        backtracks  <= auto_backtracks;
                        auto_col_q  <= auto_colouring;
                        auto_q_q    <= auto_mu_question;
                        auto_i_q    <= auto_mu_info;
                        auto_t_q    <= auto_mu_total;
                        auto_l_q    <= auto_mu_legacy;
                    end
                    if (both_fin) begin
                        state <= S_COMPARE;
                    end else if (wait_inc >= TIMEOUT) begin
                        timed_out     <= 1'b1;
                        match         <= 1'b0;
                        mismatch_mask <= '0;
                        result_valid  <= 1'b1;
                        state         <= S_REPORT;
                    end
                end
                S_COMPARE: begin
                    mismatch_mask <= mask_c;
                    match         <= (mask_c == 5'd0);
                    result_valid  <= 1'b1;
                    state         <= S_REPORT;
                end
                S_REPORT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_thiele_dual_solver_sequencer.sv
// Directed bench for the dual-solver sequencer: match, field mismatch, timeout, same-cycle level
// dones, result back-pressure with a held request, and mid-run reset.
module tb_thiele_dual_solver_sequencer;
    localparam int NODES = 9;
    localparam int CNT_W = 20;
    localparam int VW    = 1 + 5 + 1 + CNT_W + CNT_W + 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic run_req = 1'b0, run_ack, solver_start;
    logic seq_done = 1'b0, auto_done = 1'b0;
    logic [2*NODES-1:0] seq_colouring, auto_colouring;
    logic [31:0] seq_mu_question, seq_mu_info, seq_mu_total;
    logic [31:0] auto_mu_question, auto_mu_info, auto_mu_total;
    logic [5:0] seq_mu_legacy, auto_mu_legacy;
    logic [7:0] auto_backtracks;
    logic result_valid, result_ready = 1'b0;
    logic match, timed_out, busy;
    logic [4:0] mismatch_mask;
    logic [CNT_W-1:0] seq_cycles, auto_cycles;
    logic [7:0] backtracks;
    logic [2:0] state_dbg;

    int n_cmp = 0, n_bad = 0;
    int n_start = 0, n_verdict = 0, n_compare = 0;
    logic valid_prev = 1'b0;
    logic [VW-1:0] exp_q[$];

    thiele_dual_solver_sequencer #(.NODES(NODES), .TIMEOUT_CYCLES(100), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run_req(run_req), .run_ack(run_ack), .solver_start(solver_start),
        .seq_done(seq_done), .seq_colouring(seq_colouring), .seq_mu_question(seq_mu_question),
        .seq_mu_info(seq_mu_info), .seq_mu_total(seq_mu_total), .seq_mu_legacy(seq_mu_legacy),
        .auto_done(auto_done), .auto_colouring(auto_colouring), .auto_mu_question(auto_mu_question),
        .auto_mu_info(auto_mu_info), .auto_mu_total(auto_mu_total), .auto_mu_legacy(auto_mu_legacy),
        .auto_backtracks(auto_backtracks), .result_valid(result_valid), .result_ready(result_ready),
        .match(match), .mismatch_mask(mismatch_mask), .timed_out(timed_out),
        .seq_cycles(seq_cycles), .auto_cycles(auto_cycles), .backtracks(backtracks),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---- clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "bench time limit");
    end

    // ---- monitors (sample on falling edge)
    always @(negedge clk) begin
        if (solver_start) n_start++;
        if (state_dbg == 3'd3) n_compare++;
        if (result_valid && !valid_prev) n_verdict++;
        valid_prev = result_valid;
    end

    // ---- scoreboard
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] verdict_now();
        return {match, mismatch_mask, timed_out, seq_cycles, auto_cycles, backtracks};
    endfunction

    function automatic logic [VW-1:0] mk_verdict(input logic m, input logic [4:0] mk, input logic t,
                                                 input int sc, input int ac, input int bt);
        return {m, mk, t, CNT_W'(sc), CNT_W'(ac), 8'(bt)};
    endfunction

    // ---- drivers
    task automatic set_data();
        seq_colouring = 18'h24924;  auto_colouring = 18'h24924;
        seq_mu_question = 32'd1288; auto_mu_question = 32'd1288;
        seq_mu_info = 32'd934848;   auto_mu_info = 32'd934848;
        seq_mu_total = 32'd85345216; auto_mu_total = 32'd85345216;
        seq_mu_legacy = 6'd23;      auto_mu_legacy = 6'd23;
        auto_backtracks = 8'd7;
    endtask

    // Returns on the falling edge of the LAUNCH cycle.
    task automatic launch(input logic keep_req);
        int n;
        @(negedge clk);
        run_req = 1'b1;
        n = 0;
        while (run_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ack_seen", 64'(run_ack), 64'd1);
        check("start_with_ack", 64'(solver_start), 64'd1);
        if (!keep_req) run_req = 1'b0;
    endtask

    // Done set after falling edge c is sampled on the c-th rising edge after the start pulse.
    task automatic drive_dones(input int ns, input int na, input logic level, output int valid_at);
        valid_at = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (result_valid) begin
                valid_at = c;
                break;
            end
            if (!level) begin
                if (c == ns + 1) seq_done = 1'b0;
                if (c == na + 1) auto_done = 1'b0;
            end
            if (c == ns) seq_done = 1'b1;
            if (c == na) auto_done = 1'b1;
        end
        if (valid_at == 0) check("valid_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", 64'(result_valid), 64'd0);
        check("idle_after_accept", 64'(state_dbg), 64'd0);
        result_ready = 1'b0;
        seq_done = 1'b0;
        auto_done = 1'b0;
    endtask

    task automatic run_case(input string tag, input int ns, input int na, input logic level,
                            input int exp_valid_at);
        int va, s0, v0;
        s0 = n_start;
        v0 = n_verdict;
        launch(1'b0);
        drive_dones(ns, na, level, va);
        check({tag, "_valid_at"}, 64'(va), 64'(exp_valid_at));
        check({tag, "_verdict"}, 64'(verdict_now()), 64'(exp_q.pop_front()));
        accept();
        check({tag, "_starts"}, 64'(n_start - s0), 64'd1);
        check({tag, "_verdicts"}, 64'(n_verdict - v0), 64'd1);
    endtask

    // ---- stimulus
    initial begin
        int va, c0;
        set_data();
        #1;
        check("reset_outputs",
              {run_ack, solver_start, result_valid, match, mismatch_mask, timed_out,
               seq_cycles, auto_cycles, backtracks, busy, state_dbg}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Matching results, pulsed dones at 40 and 75: REPORT two cycles after the last done.
        exp_q.push_back(mk_verdict(1'b1, 5'b00000, 1'b0, 40, 75, 7));
        run_case("match", 40, 75, 1'b0, 77);

        // Colouring and total differ.
        auto_mu_total = 32'd85345217;
        auto_colouring = 18'h24925;
        auto_backtracks = 8'd9;
        exp_q.push_back(mk_verdict(1'b0, 5'b01001, 1'b0, 20, 10, 9));
        run_case("mismatch", 20, 10, 1'b0, 22);
        set_data();

        // Auto side never finishes: 100 WAIT cycles then a timed-out verdict.
        exp_q.push_back(mk_verdict(1'b0, 5'b00000, 1'b1, 30, 0, 0));
        run_case("timeout", 30, 0, 1'b0, 101);

        // Both dones in the same cycle, held as levels until the verdict is taken.
        c0 = n_compare;
        exp_q.push_back(mk_verdict(1'b1, 5'b00000, 1'b0, 12, 12, 7));
        run_case("same_cycle", 12, 12, 1'b1, 14);
        check("same_cycle_compares", 64'(n_compare - c0), 64'd1);

        // Back-pressure with run_req held throughout.
        exp_q.push_back(mk_verdict(1'b1, 5'b00000, 1'b0, 5, 8, 7));
        launch(1'b1);
        drive_dones(5, 8, 1'b0, va);
        check("hold_valid_at", 64'(va), 64'd10);
        begin
            logic [VW-1:0] e;
            e = exp_q.pop_front();
            for (int i = 0; i < 20; i++) begin
                if (i > 0) @(negedge clk);
                check("hold_stable", 64'({result_valid, run_ack, verdict_now()}), 64'({2'b10, e}));
            end
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("hold_release_valid", 64'(result_valid), 64'd0);
        check("hold_release_noack", 64'(run_ack), 64'd0);
        check("hold_release_idle", 64'(state_dbg), 64'd0);
        @(negedge clk);
        check("hold_reack", 64'({run_ack, solver_start}), 64'b11);
        run_req = 1'b0;
        exp_q.push_back(mk_verdict(1'b1, 5'b00000, 1'b0, 3, 3, 7));
        drive_dones(3, 3, 1'b0, va);
        check("rerun_valid_at", 64'(va), 64'd5);
        check("rerun_verdict", 64'(verdict_now()), 64'(exp_q.pop_front()));
        accept();

        // Reset during WAIT aborts the run with no verdict.
        c0 = n_verdict;
        launch(1'b0);
        repeat (10) @(negedge clk);
        check("pre_reset_wait", 64'(state_dbg), 64'd2);
        #2 reset = 1'b0;
        #1;
        check("midrun_reset_outputs",
              {run_ack, solver_start, result_valid, match, mismatch_mask, timed_out,
               seq_cycles, auto_cycles, backtracks, busy, state_dbg}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrun_no_verdict", 64'(n_verdict - c0), 64'd0);
        exp_q.push_back(mk_verdict(1'b1, 5'b00000, 1'b0, 40, 75, 7));
        run_case("after_reset", 40, 75, 1'b0, 77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
